param_lifo_stack: RTL and testbench

- Parametrised synchronous LIFO (stack) buffer: next generation of the team's 8-bit LIFO.
- Adds configurable width and depth, occupancy count, almost-full threshold, and a combinational top-of-stack peek.
- Adds a registered pop-data valid strobe, simultaneous push+pop (replace-top) and sticky-free overflow/underflow pulses.
- Used as a scratch stack for datapath and controller blocks in the same clock domain.

---
 rtl/lifo_pkg.sv | 15 +
 rtl/lifo_mem.sv | 33 +++
 rtl/param_lifo_stack.sv | 127 ++++++++++++
 tb/tb_param_lifo_stack.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO: pointer sizing and the
// {wn,rn} operation encoding.
package lifo_pkg;

    localparam logic [1:0] OP_IDLE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    // Pointer must represent 0..DEPTH inclusive, so it needs clog2(DEPTH+1) bits.
    function automatic int ptr_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one
// asynchronous read port. Addresses outside 0..DEPTH-1 read 0 and never write.
module lifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we && (waddr < LIMIT))
            mem_q[waddr[IW-1:0]] <= wdata;
    end

    // sp-1 underflows to all-ones when the stack is empty; the guard hides that.
    always_comb begin
        rdata = '0;
        if (raddr < LIMIT)
            rdata = mem_q[raddr[IW-1:0]];
    end

endmodule

// File: rtl/param_lifo_stack.sv
// Parametrised synchronous LIFO with occupancy, almost-full, top-of-stack
// peek, registered pop data with valid strobe, and overflow/underflow pulses.
module param_lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wn,
    input  logic                         rn,
    input  logic [WIDTH-1:0]             DATAIN,
    output logic [WIDTH-1:0]             DATAOUT,
    output logic                         dout_valid,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] AF_A    = AW'(AF_THRESH);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    logic [AW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign raddr = sp_q - ONE_A;

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (we & reset),
        .waddr (waddr),
        .wdata (DATAIN),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign count       = sp_q;
    assign full        = (sp_q == DEPTH_A);
    assign empty       = (sp_q == '0);
    assign almost_full = (sp_q >= AF_A);
    assign top         = empty ? '0 : rdata;

    assign DATAOUT     = dout_q;
    assign dout_valid  = dv_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        we     = 1'b0;
        waddr  = sp_q;
        case ({wn, rn})
            OP_IDLE: ;
            OP_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we   = 1'b1;
                    sp_d = sp_q + ONE_A;
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    dout_d = rdata;
                    dv_d   = 1'b1;
                    sp_d   = sp_q - ONE_A;
                end
            end
            OP_REPLACE: begin
                // Replace-top never overflows; on an empty stack it degrades to a push.
                we = 1'b1;
                if (empty) begin
                    unf_d = 1'b1;
                    sp_d  = ONE_A;
                end else begin
                    waddr  = raddr;
                    dout_d = rdata;
                    dv_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sp_q   <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench for param_lifo_stack: three configurations (8x8, 8x4 with
// AF_THRESH=3, 16x5) driven by one linear sequence with hand-computed values.
module tb_param_lifo_stack;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-bit x 8
    logic       wn8, rn8, dv8, full8, empty8, af8, ovf8, unf8;
    logic [7:0] din8, dout8, top8;
    logic [3:0] cnt8;
    // 8-bit x 4, AF_THRESH=3
    logic       wn4, rn4, dv4, full4, empty4, af4, ovf4, unf4;
    logic [7:0] din4, dout4, top4;
    logic [2:0] cnt4;
    // 16-bit x 5
    logic        wn5, rn5, dv5, full5, empty5, af5, ovf5, unf5;
    logic [15:0] din5, dout5, top5;
    logic [2:0]  cnt5;

    param_lifo_stack #(.WIDTH(8), .DEPTH(8)) u8 (
        .clock(clk), .reset(rst_n), .wn(wn8), .rn(rn8), .DATAIN(din8),
        .DATAOUT(dout8), .dout_valid(dv8), .top(top8), .count(cnt8),
        .full(full8), .empty(empty8), .almost_full(af8),
        .overflow(ovf8), .underflow(unf8));

    param_lifo_stack #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3)) u4 (
        .clock(clk), .reset(rst_n), .wn(wn4), .rn(rn4), .DATAIN(din4),
        .DATAOUT(dout4), .dout_valid(dv4), .top(top4), .count(cnt4),
        .full(full4), .empty(empty4), .almost_full(af4),
        .overflow(ovf4), .underflow(unf4));

    param_lifo_stack #(.WIDTH(16), .DEPTH(5)) u5 (
        .clock(clk), .reset(rst_n), .wn(wn5), .rn(rn5), .DATAIN(din5),
        .DATAOUT(dout5), .dout_valid(dv5), .top(top5), .count(cnt5),
        .full(full5), .empty(empty5), .almost_full(af5),
        .overflow(ovf5), .underflow(unf5));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp8 [7] = '{15, 65, 70, 40, 200, 150, 100};
    int psh8 [7] = '{100, 150, 200, 40, 70, 65, 15};

    initial begin
        rst_n = 1'b0;
        {wn8, rn8, wn4, rn4, wn5, rn5} = '0;
        din8 = '0; din4 = '0; din5 = '0;
        tick();
        chk("rst_count",   cnt8, 0);
        chk("rst_empty",   empty8, 1);
        chk("rst_dout",    dout8, 0);
        chk("rst_dv",      dv8, 0);
        chk("rst_top",     top8, 0);
        chk("rst_ovf_unf", {ovf8, unf8}, 0);
        rst_n = 1'b1;

        // 8x8: push seven, pop seven in reverse
        wn8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din8 = psh8[i][7:0];
            tick();
        end
        wn8 = 1'b0;
        chk("u8_cnt7",  cnt8, 7);
        chk("u8_top15", top8, 15);
        chk("u8_af7",   af8, 1);
        chk("u8_full7", full8, 0);
        rn8 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("u8_pop_data",  dout8, exp8[i]);
            chk("u8_pop_valid", dv8, 1);
            chk("u8_pop_cnt",   cnt8, 6 - i);
        end
        rn8 = 1'b0;
        tick();
        chk("u8_idle_dv", dv8, 0);
        chk("u8_empty",   empty8, 1);
        chk("u8_cnt0",    cnt8, 0);
        rn8 = 1'b1;
        tick();
        chk("u8_unf",      unf8, 1);
        chk("u8_unf_dout", dout8, 100);
        chk("u8_unf_dv",   dv8, 0);
        rn8 = 1'b0;
        tick();
        chk("u8_unf_pulse", unf8, 0);

        // 8x4: almost_full, replace-top, full, overflow
        wn4 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din4 = 8'(i);
            tick();
        end
        chk("u4_af3",   af4, 1);
        chk("u4_full3", full4, 0);
        chk("u4_cnt3",  cnt4, 3);
        rn4 = 1'b1; din4 = 8'd9;
        tick();
        chk("u4_rep_dout", dout4, 3);
        chk("u4_rep_dv",   dv4, 1);
        chk("u4_rep_cnt",  cnt4, 3);
        chk("u4_rep_top",  top4, 9);
        chk("u4_rep_ovf",  ovf4, 0);
        wn4 = 1'b0;
        tick();
        chk("u4_pop9",     dout4, 9);
        chk("u4_pop9_cnt", cnt4, 2);
        wn4 = 1'b1; rn4 = 1'b0; din4 = 8'd3;
        tick();
        din4 = 8'd4;
        tick();
        chk("u4_full",   full4, 1);
        chk("u4_cnt4",   cnt4, 4);
        chk("u4_idl_dv", dv4, 0);
        din4 = 8'd5;
        tick();
        chk("u4_ovf",     ovf4, 1);
        chk("u4_ovf_cnt", cnt4, 4);
        chk("u4_ovf_top", top4, 4);
        rn4 = 1'b1; din4 = 8'd6;
        tick();
        chk("u4_repf_dout", dout4, 4);
        chk("u4_repf_top",  top4, 6);
        chk("u4_repf_cnt",  cnt4, 4);
        chk("u4_repf_ovf",  ovf4, 0);
        wn4 = 1'b0; rn4 = 1'b0;
        tick();
        chk("u4_ovf_pulse", ovf4, 0);

        // Reset clears all stacks; replace on empty acts as push with underflow
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("u4_rst_cnt", cnt4, 0);
        wn4 = 1'b1; rn4 = 1'b1; din4 = 8'd42;
        tick();
        chk("u4_erep_unf", unf4, 1);
        chk("u4_erep_dv",  dv4, 0);
        chk("u4_erep_cnt", cnt4, 1);
        chk("u4_erep_top", top4, 42);
        wn4 = 1'b0;
        tick();
        chk("u4_pop42",     dout4, 42);
        chk("u4_pop42_unf", unf4, 0);
        wn4 = 1'b1; rn4 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            din4 = 8'(10 * i);
            tick();
        end
        chk("u4_pre_rst_cnt", cnt4, 3);
        rst_n = 1'b0; din4 = 8'd50;
        tick();
        chk("u4_mrst_cnt",   cnt4, 0);
        chk("u4_mrst_empty", empty4, 1);
        chk("u4_mrst_dout",  dout4, 0);
        chk("u4_mrst_ovf",   ovf4, 0);
        chk("u4_mrst_top",   top4, 0);
        rst_n = 1'b1; din4 = 8'd77;
        tick();
        chk("u4_p77_cnt", cnt4, 1);
        chk("u4_p77_top", top4, 77);
        wn4 = 1'b0; rn4 = 1'b1;
        tick();
        chk("u4_pop77",   dout4, 77);
        chk("u4_pop77_v", dv4, 1);
        rn4 = 1'b0;

        // 16x5 non-power-of-two depth
        wn5 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din5 = 16'(1000 * i);
            tick();
            if (i == 3) chk("u5_af_at3", af5, 0);
            if (i == 4) chk("u5_af_at4", af5, 1);
        end
        chk("u5_full",  full5, 1);
        chk("u5_cnt5",  cnt5, 5);
        chk("u5_top",   top5, 5000);
        din5 = 16'd6000;
        tick();
        chk("u5_ovf",     ovf5, 1);
        chk("u5_ovf_cnt", cnt5, 5);
        wn5 = 1'b0; rn5 = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            tick();
            chk("u5_pop_data", dout5, 1000 * i);
            chk("u5_pop_cnt",  cnt5, i - 1);
            chk("u5_pop_dv",   dv5, 1);
        end
        rn5 = 1'b0;
        tick();
        chk("u5_empty", empty5, 1);
        chk("u5_hold",  dout5, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
